// File: rtl/urp_pcie_rx_dll_acknak.sv
// Receive-side PCIe Data Link Layer: LCRC and sequence check, in-order TLP
// forwarding through an output FIFO, and coalesced ACK / NAK DLLP generation.
module urp_pcie_rx_dll_acknak #(
    parameter int TLP_W       = 224,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_THRESH  = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TLP_W+43:0] tlp_data_i,
    input  logic              tlp_data_valid_i,
    output logic              tlp_data_ready_o,
    output logic [31:0]       dllp_o,
    output logic              dllp_valid_o,
    input  logic              dllp_read_i,
    output logic [TLP_W-1:0]  tlp_data_o,
    output logic              tlp_data_valid_o,
    input  logic              tlp_data_ready_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(ACK_THRESH + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [7:0] DLLP_ACK = 8'h00;
    localparam logic [7:0] DLLP_NAK = 8'h10;

    // CRC-32 (0x04C11DB7), MSB first over {4'b0000, seq, tlp}, seeded and
    // finally inverted with all ones.
    function automatic logic [31:0] lcrc_calc(input logic [11:0] seq,
                                              input logic [TLP_W-1:0] tlp);
        logic [TLP_W+15:0] msg;
        logic [31:0]       crc;
        logic              fb;
        msg = {4'b0000, seq, tlp};
        crc = 32'hFFFF_FFFF;
        for (int i = TLP_W + 15; i >= 0; i--) begin
            fb  = crc[31] ^ msg[i];
            crc = {crc[30:0], 1'b0};
            if (fb) begin
                crc = crc ^ 32'h04C1_1DB7;
            end
        end
        return ~crc;
    endfunction

    logic              accept;
    logic              rdy_en;
    logic              vld_p0;
    logic [11:0]       seq_p0;
    logic [TLP_W-1:0]  tlp_p0;
    logic [31:0]       lcrc_p0;

    logic [11:0]       next_seq;
    logic              nak_sched;
    logic              nak_pend;
    logic              ack_pend;
    logic [CW-1:0]     ack_cnt;
    logic [TW-1:0]     ack_timer;

    logic              crc_ok;
    logic [11:0]       seq_dist;
    logic              in_order;
    logic              dup_ack;
    logic              nak_set;
    logic              ack_due;
    logic              nak_want;
    logic              ack_want;
    logic              slot_free;
    logic              launch_nak;
    logic              launch_ack;

    logic [TLP_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       fifo_cnt;
    logic [AW+1:0]     occupancy;
    logic              fifo_pop;

    // Space is reserved for the beat sitting in the check stage, so a good
    // TLP always finds a FIFO slot when it is decided.
    assign fifo_cnt         = wr_ptr - rd_ptr;
    assign occupancy        = {1'b0, fifo_cnt} + (AW+2)'(vld_p0);
    assign tlp_data_ready_o = rdy_en & (occupancy < (AW+2)'(FIFO_DEPTH));
    assign accept           = tlp_data_valid_i & tlp_data_ready_o;

    assign tlp_data_valid_o = (fifo_cnt != '0);
    assign tlp_data_o       = tlp_data_valid_o ? fifo_mem[rd_ptr[AW-1:0]] : '0;
    assign fifo_pop         = tlp_data_valid_o & tlp_data_ready_i;

    // Input ready is held off until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // Check-stage valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= accept;
        end
    end

    // Check-stage payload capture; qualified by vld_p0, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            seq_p0  <= tlp_data_i[TLP_W+43:TLP_W+32];
            tlp_p0  <= tlp_data_i[TLP_W+31:32];
            lcrc_p0 <= tlp_data_i[31:0];
        end
    end

    // Decision: distance of the received sequence behind NEXT_RCV_SEQ.
    assign crc_ok   = (lcrc_calc(seq_p0, tlp_p0) == lcrc_p0);
    assign seq_dist = next_seq - seq_p0;
    assign in_order = vld_p0 & crc_ok & (seq_dist == 12'd0);
    assign dup_ack  = vld_p0 & crc_ok & (seq_dist != 12'd0) & (seq_dist <= 12'd2048);
    assign nak_set  = vld_p0 & ~nak_sched & (~crc_ok | (seq_dist > 12'd2048));
    assign ack_due  = (ack_cnt >= CW'(ACK_THRESH)) |
                      ((ack_cnt != '0) & (ack_timer >= TW'(ACK_TIMEOUT - 1)));

    // A DLLP may launch into an empty holder or into one being read this
    // cycle; NAK wins over ACK and a losing ACK stays pending.
    assign nak_want   = nak_pend | nak_set;
    assign ack_want   = ack_pend | dup_ack | ack_due;
    assign slot_free  = ~dllp_valid_o | dllp_read_i;
    assign launch_nak = slot_free & nak_want;
    assign launch_ack = slot_free & ~nak_want & ack_want;

    // Output FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (in_order) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Output FIFO storage.
    always_ff @(posedge clk) begin
        if (in_order) begin
            fifo_mem[wr_ptr[AW-1:0]] <= tlp_p0;
        end
    end

    // Sequence tracking and NAK_SCHEDULED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_seq  <= 12'd0;
            nak_sched <= 1'b0;
        end else if (in_order) begin
            next_seq  <= next_seq + 12'd1;
            nak_sched <= 1'b0;
        end else if (nak_set) begin
            nak_sched <= 1'b1;
        end
    end

    // ACK coalescing counters; a TLP decided in the launch cycle is not yet
    // covered by that ACK, so it starts the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_cnt   <= '0;
            ack_timer <= '0;
        end else if (launch_ack) begin
            ack_cnt   <= CW'(in_order);
            ack_timer <= '0;
        end else begin
            if (in_order && (ack_cnt < CW'(ACK_THRESH))) begin
                ack_cnt <= ack_cnt + 1'b1;
            end
            if (ack_cnt == '0) begin
                ack_timer <= '0;
            end else if (ack_timer < TW'(ACK_TIMEOUT - 1)) begin
                ack_timer <= ack_timer + 1'b1;
            end
        end
    end

    // Pending request flags; repeated scheduling merges into one DLLP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nak_pend <= 1'b0;
            ack_pend <= 1'b0;
        end else begin
            nak_pend <= nak_want & ~launch_nak;
            ack_pend <= (ack_pend | dup_ack) & ~launch_ack;
        end
    end

    // DLLP holding register; seq reports the last in-order TLP at launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dllp_o       <= 32'h0;
            dllp_valid_o <= 1'b0;
        end else if (launch_nak) begin
            dllp_o       <= {DLLP_NAK, 12'h000, next_seq - 12'd1};
            dllp_valid_o <= 1'b1;
        end else if (launch_ack) begin
            dllp_o       <= {DLLP_ACK, 12'h000, next_seq - 12'd1};
            dllp_valid_o <= 1'b1;
        end else if (dllp_read_i) begin
            dllp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_urp_pcie_rx_dll_acknak.sv
// Scoreboard bench for urp_pcie_rx_dll_acknak: directed scenarios with exact
// DLLP expectations plus a randomized phase checked against a queue model.
`timescale 1ns/1ps
module tb_urp_pcie_rx_dll_acknak;

    localparam int TLP_W       = 224;
    localparam int FIFO_DEPTH  = 4;
    localparam int ACK_THRESH  = 4;
    localparam int ACK_TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [TLP_W+43:0] tlp_data_i = '0;
    logic              tlp_data_valid_i = 1'b0;
    logic              tlp_data_ready_o;
    logic [31:0]       dllp_o;
    logic              dllp_valid_o;
    logic              dllp_read_i = 1'b0;
    logic [TLP_W-1:0]  tlp_data_o;
    logic              tlp_data_valid_o;
    logic              tlp_data_ready_i = 1'b0;

    urp_pcie_rx_dll_acknak #(
        .TLP_W(TLP_W), .FIFO_DEPTH(FIFO_DEPTH),
        .ACK_THRESH(ACK_THRESH), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tlp_data_i(tlp_data_i), .tlp_data_valid_i(tlp_data_valid_i),
        .tlp_data_ready_o(tlp_data_ready_o),
        .dllp_o(dllp_o), .dllp_valid_o(dllp_valid_o), .dllp_read_i(dllp_read_i),
        .tlp_data_o(tlp_data_o), .tlp_data_valid_o(tlp_data_valid_o),
        .tlp_data_ready_i(tlp_data_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic [TLP_W-1:0] tlp; int at; } dexp_t;
    typedef struct { logic [31:0] v; int at; } kexp_t;

    dexp_t       dq[$];
    kexp_t       kq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_acc = 0;
    logic [11:0] m_next = 12'd0;
    int          tl_mode = 0;
    bit          rd_rand = 1'b0;
    bit          strict = 1'b1;
    bit          lat_chk = 1'b0;
    bit          stab_chk = 1'b0;
    logic [31:0] crc_tab [256];

    always @(posedge clk) cyc <= cyc + 1;

    // Table-driven CRC-32, byte at a time, MSB first.
    function automatic logic [31:0] ref_lcrc(input logic [11:0] s, input logic [TLP_W-1:0] t);
        logic [TLP_W+15:0] m;
        logic [31:0]       c;
        logic [7:0]        b;
        m = {4'b0000, s, t};
        c = 32'hFFFF_FFFF;
        for (int i = (TLP_W + 16) / 8 - 1; i >= 0; i--) begin
            b = m[i*8 +: 8];
            c = {c[23:0], 8'h00} ^ crc_tab[c[31:24] ^ b];
        end
        return c ^ 32'hFFFF_FFFF;
    endfunction

    function automatic logic [TLP_W-1:0] rand_tlp();
        logic [TLP_W-1:0] t;
        for (int i = 0; i < TLP_W / 8; i++) t[i*8 +: 8] = 8'($urandom);
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives the TL-side ready and the DLLP read strobe just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dllp_read_i = dllp_valid_o && (!rd_rand || ($urandom_range(0, 1) == 1));
            case (tl_mode)
                0:       tlp_data_ready_i = 1'b1;
                1:       tlp_data_ready_i = 1'b0;
                default: tlp_data_ready_i = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT hands something over.
    dexp_t       md;
    kexp_t       mk;
    logic        prev_dv = 1'b0;
    logic        prev_rd = 1'b0;
    logic [31:0] prev_d = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (tlp_data_valid_o && tlp_data_ready_i) begin
                total++;
                if (dq.size() == 0) begin
                    bad++;
                    $display("FAIL tlp_unexpected got=%h", tlp_data_o);
                end else begin
                    md = dq.pop_front();
                    if (tlp_data_o !== md.tlp) begin
                        bad++;
                        $display("FAIL tlp_data got=%h want=%h", tlp_data_o, md.tlp);
                    end
                    if (lat_chk) begin
                        total++;
                        if (cyc - md.at != 1) begin
                            bad++;
                            $display("FAIL tlp_latency got=%0d want=1", cyc - md.at);
                        end
                    end
                end
            end
            if (dllp_valid_o && dllp_read_i) begin
                total++;
                if (strict) begin
                    if (kq.size() == 0) begin
                        bad++;
                        $display("FAIL dllp_unexpected got=%h", dllp_o);
                    end else begin
                        mk = kq.pop_front();
                        if (dllp_o !== mk.v) begin
                            bad++;
                            $display("FAIL dllp_value got=%h want=%h", dllp_o, mk.v);
                        end
                        if (mk.at >= 0) begin
                            total++;
                            if (cyc != mk.at) begin
                                bad++;
                                $display("FAIL dllp_timing got=%0d want=%0d", cyc, mk.at);
                            end
                        end
                    end
                end else if (dllp_o[19:12] != 12'h0 ||
                             (dllp_o[31:24] != 8'h00 && dllp_o[31:24] != 8'h10)) begin
                    bad++;
                    $display("FAIL dllp_format got=%h want=type 00/10 zero pad", dllp_o);
                end
            end
            if (stab_chk && prev_dv && !prev_rd) begin
                total++;
                if (!dllp_valid_o || dllp_o !== prev_d) begin
                    bad++;
                    $display("FAIL dllp_hold got=%b/%h want=1/%h", dllp_valid_o, dllp_o, prev_d);
                end
            end
            prev_dv = dllp_valid_o;
            prev_rd = dllp_read_i;
            prev_d  = dllp_o;
        end else begin
            prev_dv = 1'b0;
        end
    end

    // Issues one TLP and updates the model at the accepting edge.
    task automatic send(input logic [11:0] s, input logic [TLP_W-1:0] t, input bit corrupt);
        int  w;
        bit  ok;
        logic [31:0] c;
        c = ref_lcrc(s, t) ^ (corrupt ? 32'h0000_0100 : 32'h0);
        tlp_data_i = {s, t, c};
        tlp_data_valid_i = 1'b1;
        w  = 0;
        ok = 1'b0;
        while (!ok && w < 1000) begin
            @(negedge clk);
            if (tlp_data_ready_o) ok = 1'b1;
            else w++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=no ready want=ready within 1000 cycles");
            tlp_data_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        tlp_data_valid_i = 1'b0;
        if (!corrupt && s == m_next) begin
            dq.push_back('{t, cyc});
            m_next = m_next + 12'd1;
        end
    endtask

    task automatic push_dllp(input logic [31:0] v, input int at);
        kq.push_back('{v, at});
    endtask

    task automatic drain(input string name, input int extra);
        int n;
        n = 0;
        while ((dq.size() != 0 || kq.size() != 0) && n < 400) begin
            tick(1);
            n++;
        end
        tick(extra);
        chk({name, "_tlp_left"}, 64'(dq.size()), 64'd0);
        chk({name, "_dllp_left"}, 64'(kq.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dq.delete();
        kq.delete();
        m_next = 12'd0;
        tick(3);
        chk("rst_dllp", 64'(dllp_o), 64'd0);
        chk("rst_dllp_valid", 64'(dllp_valid_o), 64'd0);
        chk("rst_tlp_data", 64'(tlp_data_o[63:0]), 64'd0);
        chk("rst_tlp_valid", 64'(tlp_data_valid_o), 64'd0);
        chk("rst_ready", 64'(tlp_data_ready_o), 64'd0);
        rst_n = 1'b1;
        chk("ready_before_edge", 64'(tlp_data_ready_o), 64'd0);
        tick(1);
        chk("ready_after_release", 64'(tlp_data_ready_o), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c;
        logic [11:0] s;
        int          r;
        for (int b = 0; b < 256; b++) begin
            c = 32'(b) << 24;
            for (int k = 0; k < 8; k++) c = c[31] ? ({c[30:0], 1'b0} ^ 32'h04C1_1DB7) : {c[30:0], 1'b0};
            crc_tab[b] = c;
        end

        // In-order burst reaching the ACK threshold.
        do_reset();
        lat_chk = 1'b1;
        push_dllp(32'h0000_0003, -1);
        for (int i = 0; i < 4; i++) send(12'(i), rand_tlp(), 1'b0);
        drain("burst4", 80);
        lat_chk = 1'b0;

        // Lone TLP acknowledged by the timer.
        do_reset();
        send(12'd0, rand_tlp(), 1'b0);
        push_dllp(32'h0000_0000, last_acc + ACK_TIMEOUT + 1);
        drain("timer_ack", 20);

        // Two bad LCRCs give one NAK; a good TLP afterwards is accepted.
        do_reset();
        push_dllp(32'h1000_0FFF, -1);
        push_dllp(32'h0000_0000, -1);
        send(12'd0, rand_tlp(), 1'b1);
        send(12'd0, rand_tlp(), 1'b1);
        tick(3);
        send(12'd0, rand_tlp(), 1'b0);
        drain("bad_lcrc", 80);

        // Duplicate forces an immediate ACK; a jump ahead gives a NAK.
        do_reset();
        push_dllp(32'h0000_0001, -1);
        push_dllp(32'h1000_0001, -1);
        send(12'd0, rand_tlp(), 1'b0);
        send(12'd1, rand_tlp(), 1'b0);
        send(12'd1, rand_tlp(), 1'b0);
        send(12'd5, rand_tlp(), 1'b0);
        drain("dup_ahead", 80);

        // Transaction Layer stalled: ready drops after four accepts.
        do_reset();
        tl_mode = 1;
        tick(1);
        push_dllp(32'h0000_0003, -1);
        push_dllp(32'h0000_0004, -1);
        for (int i = 0; i < 4; i++) send(12'(i), rand_tlp(), 1'b0);
        chk("ready_full", 64'(tlp_data_ready_o), 64'd0);
        fork
            send(12'd4, rand_tlp(), 1'b0);
            begin
                tick(10);
                chk("ready_still_full", 64'(tlp_data_ready_o), 64'd0);
                chk("fifo_valid_stalled", 64'(tlp_data_valid_o), 64'd1);
                tl_mode = 0;
            end
        join
        drain("backpressure", 80);

        // Reset in mid-operation empties the FIFO at once.
        do_reset();
        tl_mode = 1;
        tick(1);
        send(12'd0, rand_tlp(), 1'b0);
        send(12'd1, rand_tlp(), 1'b0);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_tlp_valid", 64'(tlp_data_valid_o), 64'd0);
        chk("midrst_dllp_valid", 64'(dllp_valid_o), 64'd0);
        chk("midrst_ready", 64'(tlp_data_ready_o), 64'd0);
        dq.delete();
        m_next = 12'd0;
        tick(2);
        rst_n = 1'b1;
        tl_mode = 0;
        tick(1);
        send(12'd0, rand_tlp(), 1'b0);
        push_dllp(32'h0000_0000, last_acc + ACK_TIMEOUT + 1);
        drain("midrst", 20);

        // Sequence wrap: 4104 in-order TLPs, spaced so ACKs land every fourth.
        do_reset();
        for (int k = 0; k < 1026; k++) push_dllp({20'h0, 12'((4 * k + 3) % 4096)}, -1);
        for (int i = 0; i < 4104; i++) begin
            send(12'(i % 4096), rand_tlp(), 1'b0);
            tick(1);
        end
        drain("wrap", 20);

        // Randomized traffic with TL and DLLP backpressure.
        do_reset();
        strict   = 1'b0;
        stab_chk = 1'b1;
        rd_rand  = 1'b1;
        tl_mode  = 2;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      s = m_next;
            else if (r < 82) s = m_next - 12'(1 + $urandom_range(0, 3));
            else             s = m_next + 12'(1 + $urandom_range(0, 5));
            send(s, rand_tlp(), ($urandom_range(0, 99) < 15));
            tick($urandom_range(0, 2));
        end
        tl_mode = 0;
        drain("random", 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
